cntry_road_sensor: RTL and testbench
====================================

// Module: cntry_road_sensor
// PURPOSE
// - Counterpart of the highway/country traffic signal controller: sits on the country-road side of the
//   light interface, consumes the hwy/cntry light codes and produces the vehicle sensor X.
// - Models a vehicle queue: counts arrivals, drains one car per PASS_CYC cycles of country green,
//   holds X high while cars wait.
// - Also checks light-sequence legality and minimum dwell times. Used as the bench/intersection model.
// PARAMETERS
// - QW       4  queue counter width; capacity 2**QW-1 cars
// - PASS_CYC 2  country-green cycles per departing car (>=1)
// - YEL_MIN  3  minimum cycles any yellow phase must last
// - RR_MIN   2  minimum cycles of red/red before country green
// PORTS
// - clock       in  1   single clock, all state on rising edge
// - clear_n     in  1   reset, asynchronous assert, active-low
// - hwy         in  2   highway light: 0 RED, 1 YELLOW, 2 GREEN, 3 illegal
// - cntry       in  2   country light, same encoding
// - car_arrive  in  1   one-cycle pulse per arriving car
// - X           out 1   sensor: 1 = car(s) waiting
// - queue_cnt   out QW  cars currently queued
// - car_depart  out 1   one-cycle pulse per car leaving the queue
// - drop        out 1   one-cycle pulse: arrival lost because the queue was full
// - protocol_err out 1  one-cycle pulse on any checker violation
// - err_code    out 3   code of the most recent violation; held until the next one
// - err_cnt     out 8   violation count, saturates at 255
// BEHAVIOUR
// - Reset values: X=0, queue_cnt=0, car_depart=0, drop=0, protocol_err=0, err_code=0, err_cnt=0.
//   Phase=HG_CR, dwell=0, pass timer=0.
// - All outputs are registered. Inputs sampled at edge k produce their effects on outputs after edge k.
// - Queue update:
//   - arrive only -> +1; depart only -> -1; both in the same cycle -> count unchanged, car_depart=1.
//   - At full (2**QW-1), arrive without depart -> count holds, drop=1.
//   - No departure when count==0; the timer still runs. No wrap in either direction.
// - Pass timer:
//   - Counts cycles with cntry==GREEN and resets whenever cntry!=GREEN.
//   - When it reaches PASS_CYC-1 with count>0, a depart occurs and the timer restarts at 0.
// - X = (next queue_cnt != 0), registered, so X rises in the cycle after the first arrival edge.
// - Checker phase FSM over the (hwy,cntry) pair, with a legal ring:
//   - HG_CR(G,R) -> HY_CR(Y,R) -> RR(R,R) -> HR_CG(R,G) -> HR_CY(R,Y) -> HG_CR.
//   - Any phase -> HG_CR is also legal (controller clear).
//   - dwell counts cycles in the current phase; it restarts at 1 when the pair changes.
// - Violation codes, evaluated when the sampled pair differs from the registered pair
//   (codes 1 and 2 are checked every cycle):
//   - 1 either light == 3
//   - 2 both lights non-RED
//   - 3 transition not on the ring
//   - 4 leaving HY_CR or HR_CY with dwell < YEL_MIN
//   - 5 leaving RR with dwell < RR_MIN
//   - 6 HG_CR -> HY_CR while X was 0 in the previous cycle (unrequested)
// - Violation handling:
//   - Priority is 1 > 2 > 3 > 4/5/6; only the highest code is recorded.
//   - On codes 1 and 2 the phase is held.
//   - On codes 3, 4, 5 and 6 the phase still follows the new pair, so the checker resynchronises.
// - clear_n low mid-operation: everything returns to reset values immediately, including a non-empty queue.
// STRUCTURE
// - traffic_pkg holds:
//   - light encodings RED/YELLOW/GREEN
//   - phase enum HG_CR, HY_CR, RR, HR_CG, HR_CY
//   - error code constants 1..6
//   - YEL_MIN/RR_MIN defaults matching the controller's yellow-to-red and red-to-green delays
// - Sub-module light_seq_checker: phase FSM, dwell counter, error logic.
// - The top level holds the queue, the pass timer and X.
// TESTING
// - Reset, then 3 arrivals on cycles 1,2,3 with lights (G,R) -> queue_cnt 1,2,3; X=1 from cycle 2;
//   no errors.
// - Queue=3, cntry GREEN for 6 cycles, PASS_CYC=2 -> car_depart at cycles 2,4,6; queue 2,1,0;
//   X falls after the third depart.
// - QW=2: 4 arrivals -> queue 3, drop=1 on the 4th; arrive+depart in the same cycle at full
//   -> queue stays 3, no drop.
// - Full legal ring with yellow 3 cycles and red/red 2 cycles -> err_cnt=0;
//   repeat with yellow 2 cycles -> err_code=4, err_cnt=1.
// - Drive (G,G) -> err_code=2; drive hwy=3 -> err_code=1;
//   (G,R) -> (R,G) directly -> err_code=3; phase resyncs to HR_CG.
// - (G,R) -> (Y,R) with X=0 -> err_code=6;
//   assert clear_n low while queue=2 -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the country-road side of the highway/country light interface:
// light encodings, checker phases, violation codes and default dwell minimums.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED     = 2'd0,
        YELLOW  = 2'd1,
        GREEN   = 2'd2,
        ILLEGAL = 2'd3
    } light_t;

    // Legal (hwy, cntry) pairs, in ring order.
    typedef enum logic [2:0] {
        HG_CR = 3'd0,
        HY_CR = 3'd1,
        RR    = 3'd2,
        HR_CG = 3'd3,
        HR_CY = 3'd4
    } phase_t;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_BAD_CODE  = 3'd1;
    localparam logic [2:0] ERR_CONFLICT  = 3'd2;
    localparam logic [2:0] ERR_ORDER     = 3'd3;
    localparam logic [2:0] ERR_YEL_SHORT = 3'd4;
    localparam logic [2:0] ERR_RR_SHORT  = 3'd5;
    localparam logic [2:0] ERR_UNREQ     = 3'd6;

    // Match the controller's yellow-to-red and red-to-green delays.
    localparam int DEF_YEL_MIN = 3;
    localparam int DEF_RR_MIN  = 2;

    // Successor of a phase on the normal ring.
    function automatic phase_t ring_next(input phase_t p);
        case (p)
            HG_CR:   return HY_CR;
            HY_CR:   return RR;
            RR:      return HR_CG;
            HR_CG:   return HR_CY;
            default: return HG_CR;
        endcase
    endfunction

    // Phase of a light pair; only meaningful once codes 1 and 2 are ruled out.
    function automatic phase_t pair_phase(input logic [1:0] h, input logic [1:0] c);
        if (h == YELLOW)     return HY_CR;
        else if (c == GREEN) return HR_CG;
        else if (c == YELLOW) return HR_CY;
        else if (h == RED)   return RR;
        else                 return HG_CR;
    endfunction

endpackage

// File: rtl/light_seq_checker.sv
// Tracks the (hwy, cntry) phase, counts dwell cycles in it and flags illegal
// codes, conflicting greens, off-ring transitions, short yellows/red-reds and
// unrequested country service.
module light_seq_checker import traffic_pkg::*; #(
    parameter int YEL_MIN = DEF_YEL_MIN,
    parameter int RR_MIN  = DEF_RR_MIN
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic [1:0] hwy,
    input  logic [1:0] cntry,
    input  logic       sensor,
    output logic       protocol_err,
    output logic [2:0] err_code,
    output logic [7:0] err_cnt
);

    localparam logic [7:0] YEL_MIN_W = 8'(YEL_MIN);
    localparam logic [7:0] RR_MIN_W  = 8'(RR_MIN);

    phase_t     phase_reg;
    phase_t     phase_new;
    logic [7:0] dwell_reg;
    logic       changed;
    logic [2:0] code_next;

    // Classify this cycle's pair; only the highest-priority violation is reported.
    always_comb begin
        phase_new = pair_phase(hwy, cntry);
        changed   = 1'b0;
        code_next = ERR_NONE;
        if (hwy == ILLEGAL || cntry == ILLEGAL) begin
            code_next = ERR_BAD_CODE;
        end else if (hwy != RED && cntry != RED) begin
            code_next = ERR_CONFLICT;
        end else if (phase_new != phase_reg) begin
            changed = 1'b1;
            if (phase_new != HG_CR && phase_new != ring_next(phase_reg))
                code_next = ERR_ORDER;
            else if ((phase_reg == HY_CR || phase_reg == HR_CY) && dwell_reg < YEL_MIN_W)
                code_next = ERR_YEL_SHORT;
            else if (phase_reg == RR && dwell_reg < RR_MIN_W)
                code_next = ERR_RR_SHORT;
            else if (phase_reg == HG_CR && phase_new == HY_CR && !sensor)
                code_next = ERR_UNREQ;
        end
    end

    // Phase follows any decodable pair (resync); dwell restarts at 1 on a change.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            phase_reg    <= HG_CR;
            dwell_reg    <= 8'd0;
            protocol_err <= 1'b0;
            err_code     <= ERR_NONE;
            err_cnt      <= 8'd0;
        end else begin
            if (changed) begin
                phase_reg <= phase_new;
                dwell_reg <= 8'd1;
            end else if (dwell_reg != 8'hFF) begin
                dwell_reg <= dwell_reg + 8'd1;
            end
            protocol_err <= (code_next != ERR_NONE);
            if (code_next != ERR_NONE) begin
                err_code <= code_next;
                if (err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/cntry_road_sensor.sv
// Country-road vehicle queue model: counts arrivals, releases one car every
// PASS_CYC cycles of country green, and raises X while cars wait. Light
// sequence checking is delegated to light_seq_checker.
module cntry_road_sensor import traffic_pkg::*; #(
    parameter int QW       = 4,
    parameter int PASS_CYC = 2,
    parameter int YEL_MIN  = DEF_YEL_MIN,
    parameter int RR_MIN   = DEF_RR_MIN
) (
    input  logic          clock,
    input  logic          clear_n,
    input  logic [1:0]    hwy,
    input  logic [1:0]    cntry,
    input  logic          car_arrive,
    output logic          X,
    output logic [QW-1:0] queue_cnt,
    output logic          car_depart,
    output logic          drop,
    output logic          protocol_err,
    output logic [2:0]    err_code,
    output logic [7:0]    err_cnt
);

    localparam int            TW        = (PASS_CYC > 1) ? $clog2(PASS_CYC) : 1;
    localparam logic [TW-1:0] PASS_LAST = TW'(PASS_CYC - 1);
    localparam logic [QW-1:0] Q_FULL    = {QW{1'b1}};

    logic [TW-1:0] timer_reg;
    logic          green;
    logic          timer_hit;
    logic          depart_next;
    logic          drop_next;
    logic [QW-1:0] queue_next;

    // Departure, overflow and next queue occupancy for this cycle.
    always_comb begin
        green       = (cntry == GREEN);
        timer_hit   = green && (timer_reg == PASS_LAST);
        depart_next = timer_hit && (queue_cnt != '0);
        drop_next   = car_arrive && !depart_next && (queue_cnt == Q_FULL);
        queue_next  = queue_cnt;
        if (car_arrive && !depart_next && !drop_next)
            queue_next = queue_cnt + QW'(1);
        else if (depart_next && !car_arrive)
            queue_next = queue_cnt - QW'(1);
    end

    // Pass timer wraps every PASS_CYC green cycles, even with an empty queue.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            timer_reg  <= '0;
            queue_cnt  <= '0;
            X          <= 1'b0;
            car_depart <= 1'b0;
            drop       <= 1'b0;
        end else begin
            if (!green || timer_hit)
                timer_reg <= '0;
            else
                timer_reg <= timer_reg + TW'(1);
            queue_cnt  <= queue_next;
            X          <= (queue_next != '0);
            car_depart <= depart_next;
            drop       <= drop_next;
        end
    end

    light_seq_checker #(
        .YEL_MIN (YEL_MIN),
        .RR_MIN  (RR_MIN)
    ) u_checker (
        .clock        (clock),
        .clear_n      (clear_n),
        .hwy          (hwy),
        .cntry        (cntry),
        .sensor       (X),
        .protocol_err (protocol_err),
        .err_code     (err_code),
        .err_cnt      (err_cnt)
    );

endmodule

// File: tb/tb_cntry_road_sensor.sv
// Bench for cntry_road_sensor: directed scenarios plus a randomized run, all
// checked against a behavioural intersection model kept in this file.
module tb_cntry_road_sensor;

    localparam int PASS = 2;
    localparam int YEL  = 3;
    localparam int RRM  = 2;
    localparam int CAP  = 15;

    localparam logic [1:0] R   = 2'd0;
    localparam logic [1:0] Y   = 2'd1;
    localparam logic [1:0] G   = 2'd2;
    localparam logic [1:0] BAD = 2'd3;

    logic       clock = 1'b0;
    logic       clear_n = 1'b0;
    logic [1:0] hwy = G;
    logic [1:0] cntry = R;
    logic       car_arrive = 1'b0;
    logic       X;
    logic [3:0] queue_cnt;
    logic       car_depart, drop, protocol_err;
    logic [2:0] err_code;
    logic [7:0] err_cnt;

    // Second instance with a 2-bit queue for the overflow scenario.
    logic       arrive2 = 1'b0;
    logic [1:0] cntry2 = R;
    logic [1:0] hwy2 = R;
    logic       x2, dep2, drop2, perr2;
    logic [1:0] q2;
    logic [2:0] code2;
    logic [7:0] ecnt2;

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;

    // Behavioural model state
    int m_q, m_run, m_phase, m_dwell, m_code, m_cnt;
    bit m_x, m_dep, m_drop, m_perr;

    cntry_road_sensor dut (
        .clock(clock), .clear_n(clear_n), .hwy(hwy), .cntry(cntry),
        .car_arrive(car_arrive), .X(X), .queue_cnt(queue_cnt),
        .car_depart(car_depart), .drop(drop), .protocol_err(protocol_err),
        .err_code(err_code), .err_cnt(err_cnt)
    );

    cntry_road_sensor #(.QW(2)) dut2 (
        .clock(clock), .clear_n(clear_n), .hwy(hwy2), .cntry(cntry2),
        .car_arrive(arrive2), .X(x2), .queue_cnt(q2),
        .car_depart(dep2), .drop(drop2), .protocol_err(perr2),
        .err_code(code2), .err_cnt(ecnt2)
    );

    always #5 clock = ~clock;

    // Ring position of a decodable pair, -1 otherwise.
    function automatic int pos_of(input logic [1:0] h, input logic [1:0] c);
        if (h == G && c == R) return 0;
        if (h == Y && c == R) return 1;
        if (h == R && c == R) return 2;
        if (h == R && c == G) return 3;
        if (h == R && c == Y) return 4;
        return -1;
    endfunction

    function automatic logic [1:0] pos_h(input int p);
        case (p)
            0: return G;
            1: return Y;
            5: return BAD;
            6: return G;
            default: return R;
        endcase
    endfunction

    function automatic logic [1:0] pos_c(input int p);
        case (p)
            3: return G;
            4: return Y;
            6: return Y;
            default: return R;
        endcase
    endfunction

    task automatic model_reset();
        m_q = 0; m_run = 0; m_phase = 0; m_dwell = 0; m_code = 0; m_cnt = 0;
        m_x = 0; m_dep = 0; m_drop = 0; m_perr = 0;
    endtask

    // One clock edge of the intersection, from the rules: a car leaves on every
    // PASS-th consecutive green cycle if any are waiting.
    task automatic model_edge(input bit a, input logic [1:0] h, input logic [1:0] c);
        int  p;
        int  code;
        bit  x_before;
        x_before = m_x;
        m_run  = (c == G) ? m_run + 1 : 0;
        m_dep  = (c == G) && (m_run % PASS == 0) && (m_q > 0);
        m_drop = a && !m_dep && (m_q == CAP);
        if (a && !m_drop) m_q = m_q + 1;
        if (m_dep) m_q = m_q - 1;
        m_x = (m_q != 0);

        code = 0;
        p = pos_of(h, c);
        if (h == BAD || c == BAD) begin
            code = 1; m_dwell++;
        end else if (h != R && c != R) begin
            code = 2; m_dwell++;
        end else if (p != m_phase) begin
            if (p != 0 && p != (m_phase + 1) % 5) code = 3;
            else if ((m_phase == 1 || m_phase == 4) && m_dwell < YEL) code = 4;
            else if (m_phase == 2 && m_dwell < RRM) code = 5;
            else if (m_phase == 0 && p == 1 && !x_before) code = 6;
            m_phase = p;
            m_dwell = 1;
        end else begin
            m_dwell++;
        end
        m_perr = (code != 0);
        if (code != 0) begin
            m_code = code;
            if (m_cnt < 255) m_cnt++;
        end
    endtask

    // Drive one cycle, advance the model, then settle past the edge.
    task automatic cyc(input bit a, input logic [1:0] h, input logic [1:0] c);
        car_arrive = a; hwy = h; cntry = c;
        @(posedge clock);
        model_edge(a, h, c);
        #1;
        cycle_no++;
        $display("cyc %0d arrive=%0b hwy=%0d cntry=%0d | q=%0d X=%0b dep=%0b drop=%0b perr=%0b code=%0d ecnt=%0d | q2=%0d dep2=%0b drop2=%0b",
                 cycle_no, a, h, c, queue_cnt, X, car_depart, drop, protocol_err, err_code, err_cnt, q2, dep2, drop2);
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        car_arrive = 1'b0; hwy = G; cntry = R; arrive2 = 1'b0; cntry2 = R;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        clear_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({X, queue_cnt, car_depart, drop, protocol_err, err_code, err_cnt} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got X=%0b q=%0d dep=%0b drop=%0b perr=%0b code=%0d cnt=%0d, want all 0",
                     X, queue_cnt, car_depart, drop, protocol_err, err_code, err_cnt);
        end
        checks++;
        if (q2 !== 2'd0 || x2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut2: got q2=%0d x2=%0b, want 0 0", q2, x2);
        end
    endtask

    task automatic test_arrivals();
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, G, R);
            checks++;
            if (queue_cnt !== 4'(i) || X !== 1'b1) begin
                errors++;
                $display("FAIL arrival_%0d: got q=%0d X=%0b, want q=%0d X=1", i, queue_cnt, X, i);
            end
        end
        checks++;
        if (err_cnt !== 8'd0 || protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL arrival_noerr: got cnt=%0d perr=%0b, want 0 0", err_cnt, protocol_err);
        end
    endtask

    // Legal ring walk; three cars drain during the six green cycles.
    task automatic test_drain_ring();
        repeat (3) cyc(1'b0, Y, R);
        repeat (2) cyc(1'b0, R, R);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, R, G);
            checks++;
            if (car_depart !== 1'(i % 2) || queue_cnt !== 4'(3 - (i + 1) / 2) || X !== (i < 5)) begin
                errors++;
                $display("FAIL drain_%0d: got dep=%0b q=%0d X=%0b, want dep=%0b q=%0d X=%0b",
                         i, car_depart, queue_cnt, X, i % 2, 3 - (i + 1) / 2, i < 5);
            end
        end
        repeat (3) cyc(1'b0, R, Y);
        cyc(1'b0, G, R);
        checks++;
        if (err_cnt !== 8'd0 || err_code !== 3'd0) begin
            errors++;
            $display("FAIL legal_ring: got cnt=%0d code=%0d, want 0 0", err_cnt, err_code);
        end
    endtask

    task automatic test_short_yellow();
        repeat (5) cyc(1'b1, G, R);
        repeat (2) cyc(1'b0, Y, R);
        cyc(1'b0, R, R);
        checks++;
        if (protocol_err !== 1'b1 || err_code !== 3'd4 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL short_yellow: got perr=%0b code=%0d cnt=%0d, want 1 4 1", protocol_err, err_code, err_cnt);
        end
        cyc(1'b0, R, R);
        repeat (2) cyc(1'b0, R, G);
        repeat (3) cyc(1'b0, R, Y);
        cyc(1'b0, G, R);
        checks++;
        if (err_cnt !== 8'd1 || queue_cnt !== 4'(m_q) || m_q != 4) begin
            errors++;
            $display("FAIL short_yellow_after: got cnt=%0d q=%0d, want 1 4", err_cnt, queue_cnt);
        end
    endtask

    task automatic test_illegal();
        cyc(1'b0, G, G);
        checks++;
        if (protocol_err !== 1'b1 || err_code !== 3'd2) begin
            errors++;
            $display("FAIL both_green: got perr=%0b code=%0d, want 1 2", protocol_err, err_code);
        end
        cyc(1'b0, G, R);
        checks++;
        if (protocol_err !== 1'b0 || err_code !== 3'd2) begin
            errors++;
            $display("FAIL hold_after_conflict: got perr=%0b code=%0d, want 0 2", protocol_err, err_code);
        end
        cyc(1'b0, BAD, R);
        checks++;
        if (protocol_err !== 1'b1 || err_code !== 3'd1) begin
            errors++;
            $display("FAIL bad_code: got perr=%0b code=%0d, want 1 1", protocol_err, err_code);
        end
        cyc(1'b0, G, R);
        cyc(1'b0, R, G);
        checks++;
        if (protocol_err !== 1'b1 || err_code !== 3'd3 || err_cnt !== 8'(m_cnt)) begin
            errors++;
            $display("FAIL off_ring: got perr=%0b code=%0d cnt=%0d, want 1 3 %0d", protocol_err, err_code, err_cnt, m_cnt);
        end
        cyc(1'b0, R, G);
        repeat (3) cyc(1'b0, R, Y);
        cyc(1'b0, G, R);
        checks++;
        if (err_cnt !== 8'd4 || protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL resync_hr_cg: got cnt=%0d perr=%0b, want 4 0", err_cnt, protocol_err);
        end
    endtask

    task automatic test_unrequested();
        do_reset();
        repeat (2) cyc(1'b0, G, R);
        cyc(1'b0, Y, R);
        checks++;
        if (protocol_err !== 1'b1 || err_code !== 3'd6 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL unrequested: got perr=%0b code=%0d cnt=%0d, want 1 6 1", protocol_err, err_code, err_cnt);
        end
    endtask

    task automatic test_overflow_qw2();
        do_reset();
        arrive2 = 1'b1; cntry2 = R;
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b0, G, R);
            checks++;
            if (q2 !== 2'((i > 3) ? 3 : i) || drop2 !== (i == 4)) begin
                errors++;
                $display("FAIL qw2_fill_%0d: got q2=%0d drop2=%0b, want q2=%0d drop2=%0b",
                         i, q2, drop2, (i > 3) ? 3 : i, i == 4);
            end
        end
        arrive2 = 1'b0; cntry2 = G;
        cyc(1'b0, G, R);
        arrive2 = 1'b1;
        cyc(1'b0, G, R);
        checks++;
        if (q2 !== 2'd3 || dep2 !== 1'b1 || drop2 !== 1'b0) begin
            errors++;
            $display("FAIL qw2_full_swap: got q2=%0d dep2=%0b drop2=%0b, want 3 1 0", q2, dep2, drop2);
        end
        arrive2 = 1'b0; cntry2 = R;
    endtask

    task automatic test_random();
        int cur;
        int nxt;
        int r;
        bit a;
        cur = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 15);
                if (r < 8)       nxt = (cur < 5) ? (cur + 1) % 5 : 0;
                else if (r < 14) nxt = $urandom_range(0, 4);
                else             nxt = $urandom_range(5, 6);
                cur = nxt;
            end
            a = ($urandom_range(0, 2) == 0);
            cyc(a, pos_h(cur), pos_c(cur));
            checks++;
            if (queue_cnt !== 4'(m_q) || X !== m_x || car_depart !== m_dep || drop !== m_drop ||
                protocol_err !== m_perr || err_code !== 3'(m_code) || err_cnt !== 8'(m_cnt)) begin
                errors++;
                $display("FAIL random_%0d: got q=%0d X=%0b dep=%0b drop=%0b perr=%0b code=%0d cnt=%0d, want q=%0d X=%0b dep=%0b drop=%0b perr=%0b code=%0d cnt=%0d",
                         i, queue_cnt, X, car_depart, drop, protocol_err, err_code, err_cnt,
                         m_q, m_x, m_dep, m_drop, m_perr, m_code, m_cnt);
            end
        end
    endtask

    task automatic test_async_clear();
        do_reset();
        cyc(1'b1, G, R);
        cyc(1'b1, G, G);
        checks++;
        if (queue_cnt !== 4'd2 || err_cnt !== 8'd1 || protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL pre_clear: got q=%0d cnt=%0d perr=%0b, want 2 1 1", queue_cnt, err_cnt, protocol_err);
        end
        #2;
        clear_n = 1'b0;
        #1;
        checks++;
        if ({X, queue_cnt, car_depart, drop, protocol_err, err_code, err_cnt} !== 19'd0) begin
            errors++;
            $display("FAIL async_clear: got X=%0b q=%0d dep=%0b drop=%0b perr=%0b code=%0d cnt=%0d, want all 0",
                     X, queue_cnt, car_depart, drop, protocol_err, err_code, err_cnt);
        end
        model_reset();
        car_arrive = 1'b0; hwy = G; cntry = R;
        @(negedge clock);
        clear_n = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_arrivals();
        test_drain_ring();
        test_short_yellow();
        test_illegal();
        test_unrequested();
        test_overflow_qw2();
        do_reset();
        test_random();
        test_async_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
